alu_ctrl: RTL and testbench

Sequencer that owns a small register file and drives the team's `alu` through its operation/x/y/shamt/carry_in ports. It accepts one command at a time over a valid/ready interface, reads two source registers and presents them to the ALU. It then captures result/zero/overflow, writes the result back and pulses done. It sits between the command source (bench or future decoder) and the external `alu` instance.

---
 rtl/alu_ctrl.sv | 161 ++++++++++++++++
 tb/tb_alu_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// alu_ctrl - command sequencer wrapped around an external combinational ALU.
//
// Owns a small register file and accepts one command at a time over a
// valid/ready handshake. A load writes an immediate straight into the
// register file. An ALU operation reads two source registers, registers
// them onto the ALU operand ports, lets the ALU settle for one cycle,
// captures its result and flags, then writes the result back.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_load          1 = load immediate, 0 = ALU operation
//   cmd_op/shamt      operation code and shift amount, passed to the ALU
//   cmd_use_carry     feed the stored carry flag into alu_carry_in
//   cmd_rd/rs1/rs2    destination and source register addresses
//   cmd_imm           immediate value for loads
//   alu_*  (out)      registered operands and controls for the ALU
//   alu_*  (in)       combinational result and flags from the ALU
//   done              one-cycle pulse while a command retires
//   flag_zero/carry   zero and overflow flags of the last ALU operation
//   rd_addr/rd_data   combinational debug read port of the register file
module alu_ctrl #(
    parameter int WIDTH     = 8,
    parameter int OPERATION = 3,
    parameter int SHIFT     = 3,
    parameter int REG_AW    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_load,
    input  logic [OPERATION-1:0] cmd_op,
    input  logic [SHIFT-1:0]     cmd_shamt,
    input  logic                 cmd_use_carry,
    input  logic [REG_AW-1:0]    cmd_rd,
    input  logic [REG_AW-1:0]    cmd_rs1,
    input  logic [REG_AW-1:0]    cmd_rs2,
    input  logic [WIDTH-1:0]     cmd_imm,
    output logic [OPERATION-1:0] alu_operation,
    output logic [WIDTH-1:0]     alu_x,
    output logic [WIDTH-1:0]     alu_y,
    output logic [SHIFT-1:0]     alu_shamt,
    output logic                 alu_carry_in,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_zero,
    input  logic                 alu_overflow,
    output logic                 done,
    output logic                 flag_zero,
    output logic                 flag_carry,
    input  logic [REG_AW-1:0]    rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    localparam int NUM_REGS = 1 << REG_AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic                   w_accept;

    logic [WIDTH-1:0]       r_rf [NUM_REGS];
    logic [REG_AW-1:0]      r_rd;
    logic [WIDTH-1:0]       r_wbData;
    logic                   r_isLoad;
    logic                   r_capZero;
    logic                   r_capOvf;
    logic                   r_flagZero;
    logic                   r_flagCarry;

    logic [OPERATION-1:0]   r_aluOp;
    logic [WIDTH-1:0]       r_aluX;
    logic [WIDTH-1:0]       r_aluY;
    logic [SHIFT-1:0]       r_aluShamt;
    logic                   r_aluCarryIn;

    assign cmd_ready     = (r_state == IDLE);
    assign w_accept      = cmd_valid & cmd_ready;
    assign done          = (r_state == WB);
    assign flag_zero     = r_flagZero;
    assign flag_carry    = r_flagCarry;
    assign alu_operation = r_aluOp;
    assign alu_x         = r_aluX;
    assign alu_y         = r_aluY;
    assign alu_shamt     = r_aluShamt;
    assign alu_carry_in  = r_aluCarryIn;
    assign rd_data       = r_rf[rd_addr];

    // Next-state logic: loads skip EXEC because there is nothing for the
    // ALU to compute; every command spends exactly one cycle in WB.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = cmd_load ? WB : EXEC;
            EXEC:    w_nextState = WB;
            WB:      w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath. Operands are copied out of the register file at accept
    // time, so a writeback to a source register cannot disturb an
    // operation already in flight. The ALU controls keep their value
    // outside accept so the ALU output stays stable between commands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rf         <= '{default: '0};
            r_rd         <= '0;
            r_wbData     <= '0;
            r_isLoad     <= 1'b0;
            r_capZero    <= 1'b0;
            r_capOvf     <= 1'b0;
            r_flagZero   <= 1'b0;
            r_flagCarry  <= 1'b0;
            r_aluOp      <= '0;
            r_aluX       <= '0;
            r_aluY       <= '0;
            r_aluShamt   <= '0;
            r_aluCarryIn <= 1'b0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rd     <= cmd_rd;
                        r_isLoad <= cmd_load;
                        if (cmd_load) begin
                            r_wbData <= cmd_imm;
                        end else begin
                            r_aluOp      <= cmd_op;
                            r_aluX       <= r_rf[cmd_rs1];
                            r_aluY       <= r_rf[cmd_rs2];
                            r_aluShamt   <= cmd_shamt;
                            r_aluCarryIn <= cmd_use_carry & r_flagCarry;
                        end
                    end
                end
                EXEC: begin
                    r_wbData  <= alu_result;
                    r_capZero <= alu_zero;
                    r_capOvf  <= alu_overflow;
                end
                WB: begin
                    r_rf[r_rd] <= r_wbData;
                    if (!r_isLoad) begin
                        r_flagZero  <= r_capZero;
                        r_flagCarry <= r_capOvf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl - directed self-checking bench for alu_ctrl.
//
// A behavioural ALU stub computes result = x + y + carry_in (mod 256),
// overflow = carry out, zero = (result == 0). All stimulus is driven and
// all outputs sampled 1 time unit after the rising edge.
module tb_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [2:0] cmd_op;
    logic [2:0] cmd_shamt;
    logic       cmd_use_carry;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_rs1;
    logic [1:0] cmd_rs2;
    logic [7:0] cmd_imm;
    logic [2:0] alu_operation;
    logic [7:0] alu_x;
    logic [7:0] alu_y;
    logic [2:0] alu_shamt;
    logic       alu_carry_in;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_overflow;
    logic       done;
    logic       flag_zero;
    logic       flag_carry;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;

    int checkCount = 0;
    int passCount  = 0;
    int doneCount  = 0;

    alu_ctrl #(.WIDTH(8), .OPERATION(3), .SHIFT(3), .REG_AW(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_op(cmd_op), .cmd_shamt(cmd_shamt), .cmd_use_carry(cmd_use_carry),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
        .alu_operation(alu_operation), .alu_x(alu_x), .alu_y(alu_y),
        .alu_shamt(alu_shamt), .alu_carry_in(alu_carry_in),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .done(done), .flag_zero(flag_zero), .flag_carry(flag_carry),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // Behavioural ALU stub
    logic [8:0] aluSum;
    assign aluSum       = {1'b0, alu_x} + {1'b0, alu_y} + {8'd0, alu_carry_in};
    assign alu_result   = aluSum[7:0];
    assign alu_overflow = aluSum[8];
    assign alu_zero     = (aluSum[7:0] == 8'd0);

    // Counts done pulses, sampled mid-cycle
    always @(negedge clk) if (done === 1'b1) doneCount++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setCmd(input logic load, input logic [2:0] op, input logic [2:0] shamt,
                          input logic useCarry, input logic [1:0] rd, input logic [1:0] rs1,
                          input logic [1:0] rs2, input logic [7:0] imm);
        cmd_valid     = 1'b1;
        cmd_load      = load;
        cmd_op        = op;
        cmd_shamt     = shamt;
        cmd_use_carry = useCarry;
        cmd_rd        = rd;
        cmd_rs1       = rs1;
        cmd_rs2       = rs2;
        cmd_imm       = imm;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        setCmd(1'b0, 3'd0, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 8'd0);
        cmd_valid = 1'b0;
        rd_addr = 2'd0;
        tick();
        tick();
        checkCount++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passCount++;
        checkCount++; if ({flag_zero, flag_carry} !== 2'b00) $display("[TB] FAIL reset_flags: got %b expected 00", {flag_zero, flag_carry}); else passCount++;
        checkCount++; if ({alu_operation, alu_x, alu_y, alu_shamt, alu_carry_in} !== 23'd0) $display("[TB] FAIL reset_alu_outs: got %h expected 0", {alu_operation, alu_x, alu_y, alu_shamt, alu_carry_in}); else passCount++;
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1;
            checkCount++; if (rd_data !== 8'h00) $display("[TB] FAIL reset_rf%0d: got %h expected 00", i, rd_data); else passCount++;
        end
        rst = 1'b0;
        tick();
        checkCount++; if (cmd_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", cmd_ready); else passCount++;
    endtask

    task automatic test_loads();
        logic [1:0] regs [2] = '{2'd1, 2'd2};
        logic [7:0] vals [2] = '{8'h0F, 8'hF1};
        for (int i = 0; i < 2; i++) begin
            setCmd(1'b1, 3'd0, 3'd0, 1'b0, regs[i], 2'd0, 2'd0, vals[i]);
            tick();
            cmd_valid = 1'b0;
            checkCount++; if (done !== 1'b1) $display("[TB] FAIL load%0d_done: got %b expected 1", i, done); else passCount++;
            checkCount++; if (cmd_ready !== 1'b0) $display("[TB] FAIL load%0d_busy: got %b expected 0", i, cmd_ready); else passCount++;
            tick();
            rd_addr = regs[i];
            #1;
            checkCount++; if (done !== 1'b0) $display("[TB] FAIL load%0d_done_end: got %b expected 0", i, done); else passCount++;
            checkCount++; if (rd_data !== vals[i]) $display("[TB] FAIL load%0d_data: got %h expected %h", i, rd_data, vals[i]); else passCount++;
        end
        checkCount++; if ({flag_zero, flag_carry} !== 2'b00) $display("[TB] FAIL load_flags: got %b expected 00", {flag_zero, flag_carry}); else passCount++;
    endtask

    task automatic test_alu_op();
        // r3 = r1 + r2 = 0x0F + 0xF1 = 0x100 -> 0x00, carry out
        setCmd(1'b0, 3'd0, 3'd0, 1'b0, 2'd3, 2'd1, 2'd2, 8'h00);
        tick();
        cmd_valid = 1'b0;
        checkCount++; if (alu_x !== 8'h0F) $display("[TB] FAIL op_alu_x: got %h expected 0f", alu_x); else passCount++;
        checkCount++; if (alu_y !== 8'hF1) $display("[TB] FAIL op_alu_y: got %h expected f1", alu_y); else passCount++;
        checkCount++; if (alu_carry_in !== 1'b0) $display("[TB] FAIL op_carry_in: got %b expected 0", alu_carry_in); else passCount++;
        checkCount++; if (done !== 1'b0) $display("[TB] FAIL op_done_exec: got %b expected 0", done); else passCount++;
        tick();
        checkCount++; if (done !== 1'b1) $display("[TB] FAIL op_done_wb: got %b expected 1", done); else passCount++;
        tick();
        rd_addr = 2'd3;
        #1;
        checkCount++; if (rd_data !== 8'h00) $display("[TB] FAIL op_r3: got %h expected 00", rd_data); else passCount++;
        checkCount++; if ({flag_zero, flag_carry} !== 2'b11) $display("[TB] FAIL op_flags: got %b expected 11", {flag_zero, flag_carry}); else passCount++;
    endtask

    task automatic test_carry_chain();
        // r0 = r1 + r1 + carry(1) = 0x1F
        setCmd(1'b0, 3'd0, 3'd0, 1'b1, 2'd0, 2'd1, 2'd1, 8'h00);
        tick();
        cmd_valid = 1'b0;
        checkCount++; if (alu_carry_in !== 1'b1) $display("[TB] FAIL chain_carry_in: got %b expected 1", alu_carry_in); else passCount++;
        tick();
        tick();
        rd_addr = 2'd0;
        #1;
        checkCount++; if (rd_data !== 8'h1F) $display("[TB] FAIL chain_r0: got %h expected 1f", rd_data); else passCount++;
        checkCount++; if ({flag_zero, flag_carry} !== 2'b00) $display("[TB] FAIL chain_flags: got %b expected 00", {flag_zero, flag_carry}); else passCount++;
    endtask

    task automatic test_back_to_back();
        int startDone;
        startDone = doneCount;
        // r3 = r0 + r1 = 0x1F + 0x0F = 0x2E
        setCmd(1'b0, 3'd0, 3'd0, 1'b0, 2'd3, 2'd0, 2'd1, 8'h00);
        tick();
        setCmd(1'b1, 3'd0, 3'd0, 1'b0, 2'd1, 2'd0, 2'd0, 8'h55);
        checkCount++; if (cmd_ready !== 1'b0) $display("[TB] FAIL bp_ready_exec: got %b expected 0", cmd_ready); else passCount++;
        tick();
        setCmd(1'b1, 3'd0, 3'd0, 1'b0, 2'd2, 2'd0, 2'd0, 8'h66);
        checkCount++; if (cmd_ready !== 1'b0) $display("[TB] FAIL bp_ready_wb: got %b expected 0", cmd_ready); else passCount++;
        tick();
        checkCount++; if (cmd_ready !== 1'b1) $display("[TB] FAIL bp_ready_idle: got %b expected 1", cmd_ready); else passCount++;
        rd_addr = 2'd3;
        #1;
        checkCount++; if (rd_data !== 8'h2E) $display("[TB] FAIL bp_r3: got %h expected 2e", rd_data); else passCount++;
        rd_addr = 2'd1;
        #1;
        checkCount++; if (rd_data !== 8'h0F) $display("[TB] FAIL bp_r1_untouched: got %h expected 0f", rd_data); else passCount++;
        tick();
        cmd_valid = 1'b0;
        checkCount++; if (done !== 1'b1) $display("[TB] FAIL bp_load_done: got %b expected 1", done); else passCount++;
        tick();
        rd_addr = 2'd2;
        #1;
        checkCount++; if (rd_data !== 8'h66) $display("[TB] FAIL bp_r2: got %h expected 66", rd_data); else passCount++;
        checkCount++; if (doneCount - startDone !== 2) $display("[TB] FAIL bp_done_count: got %0d expected 2", doneCount - startDone); else passCount++;
    endtask

    task automatic test_reset_mid_op();
        int startDone;
        startDone = doneCount;
        setCmd(1'b0, 3'd0, 3'd0, 1'b0, 2'd3, 2'd2, 2'd2, 8'h00);
        tick();
        cmd_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkCount++; if (done !== 1'b0) $display("[TB] FAIL rst_mid_done: got %b expected 0", done); else passCount++;
        tick();
        checkCount++; if (cmd_ready !== 1'b1) $display("[TB] FAIL rst_mid_ready: got %b expected 1", cmd_ready); else passCount++;
        checkCount++; if ({flag_zero, flag_carry} !== 2'b00) $display("[TB] FAIL rst_mid_flags: got %b expected 00", {flag_zero, flag_carry}); else passCount++;
        checkCount++; if ({alu_operation, alu_x, alu_y, alu_shamt, alu_carry_in} !== 23'd0) $display("[TB] FAIL rst_mid_alu_outs: got %h expected 0", {alu_operation, alu_x, alu_y, alu_shamt, alu_carry_in}); else passCount++;
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1;
            checkCount++; if (rd_data !== 8'h00) $display("[TB] FAIL rst_mid_rf%0d: got %h expected 00", i, rd_data); else passCount++;
        end
        checkCount++; if (doneCount !== startDone) $display("[TB] FAIL rst_mid_no_done: got %0d expected %0d", doneCount, startDone); else passCount++;
    endtask

    task automatic test_pass_through();
        setCmd(1'b0, 3'b101, 3'b100, 1'b0, 2'd1, 2'd0, 2'd0, 8'h00);
        tick();
        cmd_valid = 1'b0;
        checkCount++; if ({alu_operation, alu_shamt} !== 6'b101_100) $display("[TB] FAIL pt_exec: got %b expected 101100", {alu_operation, alu_shamt}); else passCount++;
        tick();
        tick();
        tick();
        checkCount++; if ({alu_operation, alu_shamt} !== 6'b101_100) $display("[TB] FAIL pt_idle_hold: got %b expected 101100", {alu_operation, alu_shamt}); else passCount++;
        // A load must not disturb the ALU controls
        setCmd(1'b1, 3'b010, 3'b001, 1'b0, 2'd2, 2'd0, 2'd0, 8'h33);
        tick();
        cmd_valid = 1'b0;
        tick();
        checkCount++; if ({alu_operation, alu_shamt} !== 6'b101_100) $display("[TB] FAIL pt_load_hold: got %b expected 101100", {alu_operation, alu_shamt}); else passCount++;
        setCmd(1'b0, 3'b011, 3'b010, 1'b0, 2'd1, 2'd0, 2'd2, 8'h00);
        tick();
        cmd_valid = 1'b0;
        checkCount++; if ({alu_operation, alu_shamt} !== 6'b011_010) $display("[TB] FAIL pt_new_op: got %b expected 011010", {alu_operation, alu_shamt}); else passCount++;
        checkCount++; if (alu_y !== 8'h33) $display("[TB] FAIL pt_alu_y: got %h expected 33", alu_y); else passCount++;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_loads();
        test_alu_op();
        test_carry_chain();
        test_back_to_back();
        test_reset_mid_op();
        test_pass_through();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
